fft_out_serializer: RTL and testbench



---
 rtl/fft_out_serializer.sv | 127 ++++++++++++
 tb/tb_fft_out_serializer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fft_out_serializer.sv
// Ping-pong reorder buffer for the 16-point FFT output: column words in,
// one sample per cycle out in natural index order over valid/ready.
module fft_out_serializer #(
  parameter int SAMPLE_W = 34
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [4*SAMPLE_W-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [SAMPLE_W-1:0]   out_data_o,
  output logic [3:0]            out_index_o,
  output logic                  out_last_o
);

  typedef enum logic {BANK_EMPTY = 1'b0, BANK_FULL = 1'b1} bank_state_e;

  bank_state_e         bank_q [2];
  bank_state_e         bank_d [2];
  logic                wbank_q, wbank_d;
  logic [1:0]          wcnt_q, wcnt_d;
  logic                rbank_q, rbank_d;
  logic [3:0]          rcnt_q, rcnt_d;
  logic [SAMPLE_W-1:0] mem_q [2][4][4];

  logic       in_xfer_s;
  logic       out_xfer_s;
  logic [1:0] set_s;
  logic [1:0] clr_s;

  assign in_ready_o  = (bank_q[wbank_q] == BANK_EMPTY);
  assign out_valid_o = (bank_q[rbank_q] == BANK_FULL);
  assign in_xfer_s   = in_valid_i & in_ready_o;
  assign out_xfer_s  = out_valid_o & out_ready_i;

  // Word w lane l holds sample 4*l+w, so sample n sits at word n[1:0], lane n[3:2].
  assign out_data_o  = mem_q[rbank_q][rcnt_q[1:0]][rcnt_q[3:2]];
  assign out_index_o = rcnt_q;
  assign out_last_o  = out_valid_o & (rcnt_q == 4'd15);

  always_comb begin
    set_s = {2{in_xfer_s & (wcnt_q == 2'd3)}} & (wbank_q ? 2'b10 : 2'b01);
    clr_s = {2{out_xfer_s & (rcnt_q == 4'd15)}} & (rbank_q ? 2'b10 : 2'b01);
  end

  always_comb begin
    wbank_d = wbank_q;
    wcnt_d  = wcnt_q;
    rbank_d = rbank_q;
    rcnt_d  = rcnt_q;
    if (in_xfer_s) begin
      wcnt_d = wcnt_q + 2'd1;
      if (wcnt_q == 2'd3) begin
        wbank_d = ~wbank_q;
      end else begin
        wbank_d = wbank_q;
      end
    end else begin
      wcnt_d = wcnt_q;
    end
    if (out_xfer_s) begin
      rcnt_d = rcnt_q + 4'd1;
      if (rcnt_q == 4'd15) begin
        rbank_d = ~rbank_q;
      end else begin
        rbank_d = rbank_q;
      end
    end else begin
      rcnt_d = rcnt_q;
    end
  end

  // A bank can only be set while empty and cleared while full, so both never collide.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_d[b] = bank_q[b];
      case (bank_q[b])
        BANK_EMPTY: begin
          if (set_s[b]) bank_d[b] = BANK_FULL;
          else          bank_d[b] = BANK_EMPTY;
        end
        BANK_FULL: begin
          if (clr_s[b]) bank_d[b] = BANK_EMPTY;
          else          bank_d[b] = BANK_FULL;
        end
        default: bank_d[b] = BANK_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bank_q[0] <= BANK_EMPTY;
      bank_q[1] <= BANK_EMPTY;
      wbank_q   <= 1'b0;
      wcnt_q    <= 2'd0;
      rbank_q   <= 1'b0;
      rcnt_q    <= 4'd0;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      wbank_q   <= wbank_d;
      wcnt_q    <= wcnt_d;
      rbank_q   <= rbank_d;
      rcnt_q    <= rcnt_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int b = 0; b < 2; b++) begin
        for (int w = 0; w < 4; w++) begin
          for (int l = 0; l < 4; l++) begin
            mem_q[b][w][l] <= '0;
          end
        end
      end
    end else if (in_xfer_s) begin
      for (int l = 0; l < 4; l++) begin
        mem_q[wbank_q][wcnt_q][l] <= in_data_i[SAMPLE_W*l +: SAMPLE_W];
      end
    end
  end

endmodule

// File: tb/tb_fft_out_serializer.sv
// Randomized bench for fft_out_serializer against a frame-queue reference model.
module tb_fft_out_serializer;

  localparam int SW = 34;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [4*SW-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [SW-1:0]   out_data;
  logic [3:0]      out_index;
  logic            out_last;

  always #5 clk = ~clk;

  fft_out_serializer #(.SAMPLE_W(SW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_index_o (out_index),
    .out_last_o  (out_last)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference: samples of completed, not fully drained frames in emission order.
  logic [SW-1:0]   exp_q[$];
  logic [SW-1:0]   part[16];
  int              wcnt_m = 0;
  logic [4*SW-1:0] src_word;
  bit              accepted;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_pending();
    return (exp_q.size() + 15) / 16;
  endfunction

  function automatic bit m_in_ready();
    return m_pending() < 2;
  endfunction

  function automatic bit m_out_valid();
    return m_pending() > 0;
  endfunction

  function automatic int m_index();
    int s;
    s = exp_q.size() % 16;
    return (s == 0) ? 0 : 16 - s;
  endfunction

  function automatic logic [4*SW-1:0] rand_word();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[4*SW-1:0];
  endfunction

  task automatic check_outputs();
    chk("in_ready", 64'(in_ready), 64'(m_in_ready()));
    chk("out_valid", 64'(out_valid), 64'(m_out_valid()));
    if (m_out_valid()) begin
      chk("out_data", 64'(out_data), 64'(exp_q[0]));
      chk("out_index", 64'(out_index), 64'(m_index()));
    end
    chk("out_last", 64'(out_last), 64'(m_out_valid() && (m_index() == 15)));
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic step(input bit iv, input logic [4*SW-1:0] d, input bit ordy);
    bit rdy;
    bit vld;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    rdy = m_in_ready();
    vld = m_out_valid();
    accepted = iv && rdy;
    if (vld && ordy) void'(exp_q.pop_front());
    if (accepted) begin
      for (int l = 0; l < 4; l++) part[4*l + wcnt_m] = d[SW*l +: SW];
      wcnt_m++;
      if (wcnt_m == 4) begin
        for (int n = 0; n < 16; n++) exp_q.push_back(part[n]);
        wcnt_m = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic src_step(input bit iv, input bit ordy);
    step(iv, src_word, ordy);
    if (accepted) src_word = rand_word();
  endtask

  task automatic reset_now();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    wcnt_m = 0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_index", 64'(out_index), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outputs();
  endtask

  initial begin
    logic [4*SW-1:0] d;
    logic [3:0]      pat;

    @(negedge clk);
    reset_now();

    // Directed frame: lane l of word w = 16'h100*w + l.
    for (int w = 0; w < 4; w++) begin
      d = '0;
      for (int l = 0; l < 4; l++) d[SW*l +: SW] = SW'(16'h100 * w + l);
      step(1'b1, d, 1'b1);
    end
    for (int i = 0; i < 17; i++) step(1'b0, '0, 1'b1);

    // Back-to-back frames with in_valid held high.
    src_word = rand_word();
    for (int i = 0; i < 40; i++) src_step(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) src_step(1'b0, 1'b1);

    // Output backpressure 1,0,0,1.
    pat = 4'b1001;
    for (int i = 0; i < 80; i++) src_step(i < 4, pat[i % 4]);

    // Both banks full, extra words offered then drain.
    for (int i = 0; i < 12; i++) src_step(1'b1, 1'b0);
    for (int i = 0; i < 40; i++) src_step(1'b0, 1'b1);

    // Reset with a frame half-drained and the next half-written.
    for (int i = 0; i < 4; i++) src_step(1'b1, 1'b0);
    for (int i = 0; i < 2; i++) src_step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) src_step(1'b0, 1'b1);
    reset_now();
    for (int i = 0; i < 4; i++) src_step(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) src_step(1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      src_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 40; i++) src_step(1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
